// File: rtl/bus_interconnect.sv
// Table-driven address decoder and response mux between the picorv32 native
// bus and N memory-mapped slaves, with a timeout watchdog and error capture.
module bus_interconnect #(
  parameter int                         NUM_SLAVES     = 5,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE       = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK       = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter int                         TIMEOUT_CYCLES = 256,
  parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    slv_sel,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  input  logic [NUM_SLAVES*32-1:0] slv_rdata,
  input  logic                     err_clear,
  output logic                     err_irq,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_SLAVES-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_irq_q, err_irq_d;
  logic [31:0]            err_addr_q, err_addr_d;
  logic [7:0]             err_count_q, err_count_d;

  logic                   hit_s;
  logic [IDX_W-1:0]       hit_idx_s;
  logic                   sel_ready_s;
  logic [31:0]            sel_rdata_s;
  logic                   mem_ready_s;
  logic [31:0]            mem_rdata_s;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      hit_idx_s = ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) ? IDX_W'(i) : hit_idx_s;
      hit_s     = hit_s | ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
    end
  end

  // Ready and read data of the latched slave only; other slaves are ignored.
  always_comb begin
    sel_ready_s = 1'b0;
    sel_rdata_s = 32'h0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_ready_s = (idx_q == IDX_W'(i)) ? slv_ready[i] : sel_ready_s;
      sel_rdata_s = (idx_q == IDX_W'(i)) ? slv_rdata[32*i +: 32] : sel_rdata_s;
    end
  end

  // Next-state logic for the transaction FSM, watchdog and error capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    err_irq_d   = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if (err_clear) begin
      err_addr_d  = 32'h0;
      err_count_d = 8'h0;
    end else begin
      err_addr_d  = err_addr_q;
      err_count_d = err_count_q;
    end
    case (state_q)
      IDLE: begin
        if (mem_valid && hit_s) begin
          idx_d   = hit_idx_s;
          cnt_d   = '0;
          state_d = BUSY;
          for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_d[i] = (hit_idx_s == IDX_W'(i));
          end
        end else if (mem_valid) begin
          state_d   = ERR;
          err_irq_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!mem_valid) begin
          sel_d   = '0;
          state_d = IDLE;
        end else if (sel_ready_s) begin
          sel_d   = '0;
          state_d = IDLE;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          sel_d     = '0;
          state_d   = ERR;
          err_irq_d = 1'b1;
        end else begin
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        // A fault in the same cycle as a clear still gets recorded.
        state_d     = IDLE;
        err_addr_d  = mem_addr;
        err_count_d = err_clear ? 8'd1 : sat_inc8(err_count_q);
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Response to the CPU: slave data on a qualified ready, fixed pattern on error.
  always_comb begin
    mem_ready_s = 1'b0;
    mem_rdata_s = 32'h0;
    case (state_q)
      BUSY: begin
        if (mem_valid && sel_ready_s) begin
          mem_ready_s = 1'b1;
          mem_rdata_s = sel_rdata_s;
        end else begin
          mem_ready_s = 1'b0;
          mem_rdata_s = 32'h0;
        end
      end
      ERR: begin
        mem_ready_s = 1'b1;
        mem_rdata_s = ERR_RDATA;
      end
      default: begin
        mem_ready_s = 1'b0;
        mem_rdata_s = 32'h0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      err_irq_q   <= 1'b0;
      err_addr_q  <= 32'h0;
      err_count_q <= 8'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      err_irq_q   <= err_irq_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign slv_sel   = sel_q;
  assign mem_ready = mem_ready_s;
  assign mem_rdata = mem_rdata_s;
  assign err_irq   = err_irq_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_bus_interconnect;

  localparam int NS  = 5;
  localparam int TMO = 8;
  localparam logic [NS*32-1:0] BASES = {32'h3000_0000, 32'h0000_8000, 32'h1000_0000,
                                        32'h0002_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000,
                                        32'hFFFF_E000, 32'hFFFF_0000};

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            mem_valid = 1'b0;
  logic [31:0]     mem_addr = 32'h0;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic [NS-1:0]   slv_sel;
  logic [NS-1:0]   slv_ready = '0;
  logic [NS*32-1:0] slv_rdata = '0;
  logic            err_clear = 1'b0;
  logic            err_irq;
  logic [31:0]     err_addr;
  logic [7:0]      err_count;

  bus_interconnect #(
    .NUM_SLAVES(NS), .SLV_BASE(BASES), .SLV_MASK(MASKS),
    .TIMEOUT_CYCLES(TMO), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .slv_sel(slv_sel),
    .slv_ready(slv_ready), .slv_rdata(slv_rdata), .err_clear(err_clear),
    .err_irq(err_irq), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an in-flight transaction (target slave, cycles spent selected),
  // a pending error response, and the error log.
  bit          m_busy, m_err_now, e_ready_last;
  int          m_slave, m_sel_cycles;
  logic [7:0]  m_cnt;
  logic [31:0] m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    logic [31:0] b, m;
    for (int i = 0; i < NS; i++) begin
      b = BASES[32*i +: 32];
      m = MASKS[32*i +: 32];
      if ((a & m) == b) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err_now = 0; e_ready_last = 0;
    m_slave = 0; m_sel_cycles = 0; m_cnt = 8'h0; m_addr = 32'h0;
  endtask

  task automatic compare();
    logic [NS-1:0] one, e_sel;
    logic          e_ready, e_irq;
    logic [31:0]   e_rdata;
    one     = 1;
    e_sel   = m_busy ? (one << m_slave) : '0;
    e_ready = 1'b0; e_irq = 1'b0; e_rdata = 32'h0;
    if (m_err_now) begin
      e_ready = 1'b1; e_irq = 1'b1; e_rdata = 32'hDEAD_BEEF;
    end else if (m_busy && mem_valid && slv_ready[m_slave]) begin
      e_ready = 1'b1; e_rdata = slv_rdata[32*m_slave +: 32];
    end
    check("slv_sel", 32'(slv_sel), 32'(e_sel));
    check("mem_ready", 32'(mem_ready), 32'(e_ready));
    check("mem_rdata", mem_rdata, e_rdata);
    check("err_irq", 32'(err_irq), 32'(e_irq));
    check("err_addr", err_addr, m_addr);
    check("err_count", 32'(err_count), 32'(m_cnt));
    e_ready_last = e_ready;
  endtask

  task automatic advance();
    if (m_err_now) begin
      m_err_now = 0;
      m_addr    = mem_addr;
      m_cnt     = err_clear ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
    end else begin
      if (err_clear) begin
        m_cnt = 8'h0; m_addr = 32'h0;
      end
      if (m_busy) begin
        m_sel_cycles++;
        if (!mem_valid || slv_ready[m_slave]) m_busy = 0;
        else if (m_sel_cycles == TMO) begin
          m_busy = 0; m_err_now = 1;
        end
      end else if (mem_valid) begin
        if (decode(mem_addr) < 0) m_err_now = 1;
        else begin
          m_busy = 1; m_slave = decode(mem_addr); m_sel_cycles = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    advance();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return {16'h0000, r[15:0]};
      1: return 32'h0002_0000 | (r & 32'h0000_1FFF);
      2: return 32'h1000_0000 | (r & 32'h0000_0FFF);
      3: return 32'h0000_8000 | (r & 32'h0000_0FFF);
      4: return 32'h3000_0000 | (r & 32'h0000_00FF);
      5: return 32'h4000_0000 | (r & 32'h00FF_FFFF);
      default: return r;
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rst_sel", 32'(slv_sel), 32'h0);
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_irq", 32'(err_irq), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);

    // Mapped read to slave 1, ready one cycle after select.
    mem_valid = 1'b1; mem_addr = 32'h0002_0010;
    tick();
    #1 check("map_sel", 32'(slv_sel), 32'h2);
    check("map_wait_ready", 32'(mem_ready), 32'h0);
    tick();
    slv_ready = 5'b00010; slv_rdata[63:32] = 32'h1111_2222;
    #1 check("map_ready", 32'(mem_ready), 32'h1);
    check("map_rdata", mem_rdata, 32'h1111_2222);
    check("map_irq", 32'(err_irq), 32'h0);
    tick();
    mem_valid = 1'b0; slv_ready = '0;
    #1 check("map_desel", 32'(slv_sel), 32'h0);

    // Unmapped access.
    mem_valid = 1'b1; mem_addr = 32'h4000_0000;
    tick();
    #1 check("unm_sel", 32'(slv_sel), 32'h0);
    check("unm_ready", 32'(mem_ready), 32'h1);
    check("unm_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("unm_irq", 32'(err_irq), 32'h1);
    tick();
    mem_valid = 1'b0;
    #1 check("unm_err_addr", err_addr, 32'h4000_0000);
    check("unm_err_count", 32'(err_count), 32'h1);
    check("unm_irq_drop", 32'(err_irq), 32'h0);

    // Hung slave 2 with a spurious ready from slave 3.
    mem_valid = 1'b1; mem_addr = 32'h1000_0004;
    tick();
    for (int k = 0; k < TMO; k++) begin
      slv_ready = 5'b01000;
      #1 check("tmo_sel", 32'(slv_sel), 32'h4);
      check("tmo_no_ready", 32'(mem_ready), 32'h0);
      tick();
    end
    slv_ready = '0;
    #1 check("tmo_desel", 32'(slv_sel), 32'h0);
    check("tmo_ready", 32'(mem_ready), 32'h1);
    check("tmo_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("tmo_irq", 32'(err_irq), 32'h1);
    tick();
    mem_valid = 1'b0;
    #1 check("tmo_err_count", 32'(err_count), 32'h2);
    check("tmo_err_addr", err_addr, 32'h1000_0004);

    // Overlap of slaves 0 and 3: slave 0 wins.
    mem_valid = 1'b1; mem_addr = 32'h0000_8010;
    tick();
    #1 check("ovl_sel", 32'(slv_sel), 32'h1);
    slv_ready = 5'b01001; slv_rdata[31:0] = 32'hA5A5_0000; slv_rdata[127:96] = 32'h3333_3333;
    #1 check("ovl_rdata", mem_rdata, 32'hA5A5_0000);
    tick();
    mem_valid = 1'b0; slv_ready = '0;

    // Error counter saturation, clear, and clear colliding with an error.
    for (int i = 0; i < 300; i++) begin
      mem_valid = 1'b1; mem_addr = 32'h4000_0000 + 32'(i << 4);
      tick(); tick();
    end
    mem_valid = 1'b0;
    #1 check("sat_count", 32'(err_count), 32'hFF);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #1 check("clr_count", 32'(err_count), 32'h0);
    check("clr_addr", err_addr, 32'h0);
    mem_valid = 1'b1; mem_addr = 32'h5000_0000;
    repeat (4) tick();
    #1 check("two_err_count", 32'(err_count), 32'h2);
    mem_addr = 32'h5000_0100;
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0; mem_valid = 1'b0;
    #1 check("clr_vs_err_count", 32'(err_count), 32'h1);
    check("clr_vs_err_addr", err_addr, 32'h5000_0100);

    // Asynchronous reset while BUSY.
    mem_valid = 1'b1; mem_addr = 32'h3000_0010;
    tick();
    #1 check("pre_rst_sel", 32'(slv_sel), 32'h10);
    #1 reset_n = 1'b0;
    #1 check("arst_sel", 32'(slv_sel), 32'h0);
    check("arst_ready", 32'(mem_ready), 32'h0);
    check("arst_irq", 32'(err_irq), 32'h0);
    check("arst_count", 32'(err_count), 32'h0);
    model_reset();
    mem_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    mem_valid = 1'b1; mem_addr = 32'h0002_0100;
    tick();
    #1 check("post_rst_sel", 32'(slv_sel), 32'h2);
    slv_ready = 5'b00010;
    tick();
    mem_valid = 1'b0; slv_ready = '0;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (mem_valid && e_ready_last) begin
        if ($urandom_range(0, 3) != 0) mem_addr = rand_addr();
        else mem_valid = 1'b0;
      end else if (mem_valid) begin
        if ($urandom_range(0, 31) == 0) mem_valid = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        mem_valid = 1'b1; mem_addr = rand_addr();
      end
      for (int s = 0; s < NS; s++) begin
        slv_ready[s] = ($urandom_range(0, 2) == 0);
        slv_rdata[32*s +: 32] = $urandom;
      end
      err_clear = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
